// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 initial hash value, engine state encoding and the
// round helper functions shared by the compression datapath.
package sha256_pkg;

   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   typedef enum logic [1:0] {S_IDLE, S_ROUNDS, S_FINAL} state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha256_round_fn.sv
// sha256_round_fn: one combinational SHA-256 compression round over the
// packed working registers {a,b,c,d,e,f,g,h}, a in the top word.
module sha256_round_fn
   import sha256_pkg::*;
(
   input  logic [255:0] work_i,
   input  logic [31:0]  k_i,
   input  logic [31:0]  w_i,
   output logic [255:0] work_o
);

   logic [31:0] a, b, c, d, e, f, g, h, t1, t2;

   always_comb begin
      {a, b, c, d, e, f, g, h} = work_i;
      t1 = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
      t2 = big_sigma0(a) + maj(a, b, c);
      work_o = {t1 + t2, a, b, c, d + t1, e, f, g};
   end

endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: 64-round SHA-256 compression FSM with stallable K/W
// feed and a running H accumulator for chained multi-block messages.
module sha256_round_engine
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64,
   localparam int RW = $clog2(ROUNDS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          first_block,
   input  logic [31:0]   k_value,
   input  logic [31:0]   w_value,
   input  logic          kw_valid,
   output logic [RW-1:0] round_index,
   output logic          busy,
   output logic          hash_done,
   output logic [255:0]  hash_out
);

   state_t        state_q;
   logic [RW-1:0] idx_q;
   logic          busy_q, done_q;
   logic [255:0]  h_q, work_q, work_d, hsum_d;
   logic          last;

   sha256_round_fn u_round (
      .work_i (work_q),
      .k_i    (k_value),
      .w_i    (w_value),
      .work_o (work_d)
   );

   always_comb begin
      for (int i = 0; i < 8; i++) hsum_d[32*i +: 32] = h_q[32*i +: 32] + work_q[32*i +: 32];
   end

   assign last = idx_q == RW'(ROUNDS - 1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         h_q     <= IV;
         work_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               work_q  <= first_block ? IV : h_q;
               h_q     <= first_block ? IV : h_q;
               idx_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= S_ROUNDS;
            end
            S_ROUNDS: if (kw_valid) begin
               work_q  <= work_d;
               idx_q   <= last ? '0 : idx_q + 1'b1;
               state_q <= last ? S_FINAL : S_ROUNDS;
            end
            S_FINAL: begin
               h_q     <= hsum_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign round_index = idx_q;
   assign busy        = busy_q;
   assign hash_done   = done_q;
   assign hash_out    = h_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine: drives known and random blocks with random K/W
// stalls and checks digests, timing and control against a software SHA-256.
module tb_sha256_round_engine;

   localparam logic [255:0] IV_REF = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clock = 1'b0;
   logic         reset, start, first_block, kw_valid;
   logic [31:0]  k_value, w_value;
   logic [5:0]   round_index;
   logic         busy, hash_done;
   logic [255:0] hash_out;

   logic [31:0]  blk [16];
   logic [31:0]  wsch [64];
   logic [255:0] h_model;
   int           n_chk = 0, n_fail = 0;

   always #5 clock = ~clock;

   assign k_value = KT[round_index];
   assign w_value = wsch[round_index];

   sha256_round_engine dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .first_block (first_block),
      .k_value     (k_value),
      .w_value     (w_value),
      .kw_valid    (kw_valid),
      .round_index (round_index),
      .busy        (busy),
      .hash_done   (hash_done),
      .hash_out    (hash_out)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic expand();
      for (int i = 0; i < 64; i++) begin
         if (i < 16) wsch[i] = blk[i];
         else wsch[i] = (rr(wsch[i-2], 17) ^ rr(wsch[i-2], 19) ^ (wsch[i-2] >> 10)) + wsch[i-7]
                      + (rr(wsch[i-15], 7) ^ rr(wsch[i-15], 18) ^ (wsch[i-15] >> 3)) + wsch[i-16];
      end
   endtask

   function automatic logic [255:0] compress(input logic [255:0] hin);
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int j = 0; j < 64; j++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[j] + wsch[j];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return r;
   endfunction

   // Called on a negedge; returns on the negedge where hash_done is seen, so a
   // following call starts the next block in the done cycle.
   task automatic run_block(input logic f, input int stall_pct, input int poke, input int abort_r);
      logic [255:0] hstart, exp;
      int rounds, stalls, done_at;
      bit poked, bad;
      expand();
      hstart = f ? IV_REF : h_model;
      exp = compress(hstart);
      rounds = 0; stalls = 0; done_at = -1; poked = 0;
      start = 1'b1; first_block = f; kw_valid = 1'($urandom_range(1));
      @(negedge clock);
      start = 1'b0;
      for (int n = 1; n <= 1000 && done_at < 0; n++) begin
         if (abort_r >= 0 && rounds == abort_r) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_ridx", round_index, 0);
            chk("abort_hash", hash_out, IV_REF);
            chk("abort_done", hash_done, 0);
            bad = 0;
            repeat (80) begin
               @(negedge clock);
               if (hash_done) bad = 1;
            end
            chk("abort_no_done", bad, 0);
            h_model = IV_REF;
            return;
         end
         if (poke >= 0 && rounds == poke && !poked) begin
            start = 1'b1; first_block = 1'b1; poked = 1;
         end
         kw_valid = $urandom_range(99) >= stall_pct;
         if (rounds < 64) begin
            if (kw_valid) rounds++;
            else stalls++;
         end
         @(negedge clock);
         start = 1'b0;
         if (hash_done) done_at = n;
         chk("ridx", round_index, rounds % 64);
         chk("busy", busy, hash_done ? 0 : 1);
         if (!hash_done) chk("hold_h", hash_out, hstart);
      end
      chk("done_at", done_at, 65 + stalls);
      chk("digest", hash_out, exp);
      h_model = exp;
   endtask

   task automatic set_abc();
      blk = '{default: 32'h0};
      blk[0] = 32'h61626380; blk[15] = 32'h00000018;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; first_block = 1'b0; kw_valid = 1'b0; h_model = IV_REF;
      blk = '{default: 32'h0};
      expand();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", hash_done, 0);
      chk("rst_hash", hash_out, IV_REF);
      chk("rst_ridx", round_index, 0);

      set_abc();
      run_block(1'b1, 0, -1, -1);
      chk("abc", hash_out, ABC_DIG);
      @(negedge clock);
      chk("done_clear", hash_done, 0);
      chk("abc_hold", hash_out, ABC_DIG);

      blk = '{default: 32'h0};
      blk[0] = 32'h80000000;
      run_block(1'b1, 30, -1, -1);
      chk("empty", hash_out, EMPTY_DIG);
      @(negedge clock);

      blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
              32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      run_block(1'b1, 0, -1, -1);
      blk = '{default: 32'h0};
      blk[15] = 32'h000001c0;
      run_block(1'b0, 0, -1, -1);
      chk("two_block", hash_out, TWO_DIG);
      @(negedge clock);

      set_abc();
      run_block(1'b1, 0, 10, -1);
      chk("abc_poke", hash_out, ABC_DIG);
      @(negedge clock);

      set_abc();
      run_block(1'b1, 0, -1, 30);
      set_abc();
      run_block(1'b1, 0, -1, -1);
      chk("abc_after_abort", hash_out, ABC_DIG);

      repeat (6) begin
         for (int i = 0; i < 16; i++) blk[i] = $urandom;
         run_block(1'($urandom_range(1)), $urandom_range(50), -1, -1);
         if ($urandom_range(1) == 1) @(negedge clock);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sha256_round_engine.md
Name: sha256_round_engine

Overview:
SHA-256 compression stage that sits directly downstream of k_vector. It consumes one round constant (cur_k_value from k_vector) and one message-schedule word per round. It runs the 64 compression rounds over working registers a..h, then folds the result into the running hash H0..H7. It supports single-block and chained multi-block messages; the 256-bit digest is exposed with a one-cycle done pulse.

Parameters:
ROUNDS, 64, number of compression rounds per block; round counter width is $clog2(ROUNDS).

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  begin compressing one block; sampled only in IDLE
first_block  input  1  sampled with start: 1 = seed H from IV, 0 = chain from current H
k_value  input  32  round constant K[round_index], driven by k_vector cur_k_value
w_value  input  32  message schedule word W[round_index]
kw_valid  input  1  k_value/w_value valid for current round_index; round executes only when high
round_index  output  $clog2(ROUNDS)  round the engine is waiting on; upstream addresses K/W with it
busy  output  1  high from the edge accepting start until the FINAL edge
hash_done  output  1  one-cycle pulse: hash_out updated with this block's result
hash_out  output  256  {H0,...,H7}, H0 in bits [255:224]

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, round_index=0, busy=0, hash_done=0, H0..H7=SHA-256 IV (6a09e667 ... 5be0cd19), a..h=0.
- States: IDLE, ROUNDS, FINAL.
- IDLE, start=1 at edge t:
  - If first_block=1: H and a..h both load IV.
  - Otherwise: a..h load current H.
  - Also round_index<=0, busy<=1, next state ROUNDS.
- IDLE, start=0: hold all state.
- ROUNDS, kw_valid=1: apply one round; all adds are mod 2^32 and carries are dropped.
  - T1 = h + Sigma1(e) + Ch(e,f,g) + k_value + w_value
  - T2 = Sigma0(a) + Maj(a,b,c)
  - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2
  - round_index increments. On the edge executing round ROUNDS-1, round_index wraps to 0 and the next state is FINAL.
- ROUNDS, kw_valid=0: stall; no register changes. Stalls are unbounded.
- FINAL, one edge:
  - Hi <= Hi + working_i (mod 2^32).
  - hash_done<=1, busy<=0, next state IDLE.
  - hash_done clears on the following edge.
- Latency with kw_valid held high: start at edge t, rounds at edges t+1..t+64, FINAL at t+65. hash_done and the new hash_out are visible in cycle t+65..t+66. Each stall cycle adds one cycle.
- Ignored inputs:
  - start while busy (ROUNDS or FINAL) is ignored; it is not queued.
  - kw_valid in IDLE or FINAL is ignored.
- start may be asserted in the cycle hash_done is high (back-to-back blocks). With first_block=0 it chains from the just-updated H.
- hash_out is combinationally H and is stable except on FINAL edges, IV loads and reset.
- Reset mid-block: immediate return to IDLE with all reset values. The partial block is discarded and no hash_done is issued.

Decomposition:
- Package sha256_pkg holds:
  - the 8 IV constants
  - the state encoding (IDLE, ROUNDS, FINAL)
  - functions Sigma0, Sigma1, Ch, Maj as pure 32-bit rotate/xor/logic
- Sub-module sha256_round_fn is the natural split: purely combinational, with inputs a..h, k, w and outputs next a..h.
- The engine itself is the FSM, counter and H accumulator.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, hash_done=0, hash_out=6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19.
- "abc" padded block; start+first_block=1; kw_valid held high -> hash_done exactly 65 cycles after start edge, hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty-message block with kw_valid deasserted pseudo-randomly (~30%) -> hash_out=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; done cycle = 65 + stall count.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with first_block=1, block 2 started the cycle hash_done pulses with first_block=0 -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Start pulsed again at round 10 of an "abc" run -> ignored; round_index continues and the digest is still the "abc" value.
- Reset asserted at round 30 -> next cycle busy=0, round_index=0, hash_out=IV, no hash_done; a subsequent "abc" run yields the correct digest.
